// File: rtl/host_stim_sequencer_if.sv
// Host command bus and node-facing strobes of host_stim_sequencer.
// Defining HOST_STIM_CNT_EN adds the done_count/err_count statistics signals.
interface host_stim_sequencer_if #(
    parameter int NUM_NODES = 4
);
    // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
    // the host holds cmd_type/node/addr/data stable while cmd_valid is high and cmd_ready low.
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_type;
    logic [7:0]           cmd_node;
    logic [31:0]          cmd_addr;
    logic [31:0]          cmd_data;
    logic [NUM_NODES-1:0] prog_load_enable;
    logic [NUM_NODES-1:0] prog_load_write;
    logic [31:0]          prog_load_addr;
    logic [31:0]          prog_load_data;
    logic [7:0]           ext_node_select;
    logic [7:0]           ext_neuron_id;
    logic [31:0]          ext_input_current;
    logic                 ext_input_valid;
    logic                 busy;
    logic                 err_pulse;
    logic [2:0]           dbg_state;
`ifdef HOST_STIM_CNT_EN
    logic [15:0]          done_count;
    logic [7:0]           err_count;
`endif

    modport master (
        output cmd_valid, cmd_type, cmd_node, cmd_addr, cmd_data,
`ifdef HOST_STIM_CNT_EN
        input  done_count, err_count,
`endif
        input  cmd_ready, prog_load_enable, prog_load_write, prog_load_addr,
               prog_load_data, ext_node_select, ext_neuron_id, ext_input_current,
               ext_input_valid, busy, err_pulse, dbg_state
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_node, cmd_addr, cmd_data,
`ifdef HOST_STIM_CNT_EN
        output done_count, err_count,
`endif
        output cmd_ready, prog_load_enable, prog_load_write, prog_load_addr,
               prog_load_data, ext_node_select, ext_neuron_id, ext_input_current,
               ext_input_valid, busy, err_pulse, dbg_state
    );
endinterface

// File: rtl/host_stim_sequencer.sv
// Queues host commands and replays them as program-load writes or current injections
// (each injection followed by a trigger pulse). HOST_STIM_CNT_EN enables statistics counters.
module host_stim_sequencer #(
    parameter int MESH_SIZE_X          = 2,
    parameter int MESH_SIZE_Y          = 2,
    parameter int NUM_NEURONS_PER_BANK = 4,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                 cpu_clk,
    input  logic                 rst,
    host_stim_sequencer_if.slave bus
);
    localparam int NUM_NODES = MESH_SIZE_X * MESH_SIZE_Y;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic        typ;
        logic [7:0]  node;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_LOAD_REL = 3'd2,
        S_INJ      = 3'd3,
        S_INJ_GAP  = 3'd4,
        S_TRIG     = 3'd5,
        S_TRIG_REL = 3'd6
    } state_t;

    // Command queue
    cmd_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             ready;
    logic             push;
    logic             pop;
    cmd_t             cmd_in;
    cmd_t             head;

    // Sequencer state and registered outputs
    state_t               state_q, state_d;
    logic [NUM_NODES-1:0] load_sel_q, load_sel_d;
    logic [31:0]          load_addr_q, load_addr_d;
    logic [31:0]          load_data_q, load_data_d;
    logic [7:0]           node_sel_q, node_sel_d;
    logic [7:0]           neuron_id_q, neuron_id_d;
    logic [31:0]          current_q, current_d;
    logic                 inj_valid_q, inj_valid_d;
    logic                 err_pulse_q, err_pulse_d;

    // Decode of the queue head
    logic [3:0]           head_x;
    logic [3:0]           head_y;
    logic                 node_ok;
    logic                 neuron_ok;
    logic                 cmd_ok;
    logic                 can_dispatch;
    logic [NUM_NODES-1:0] node_onehot;

    always_comb begin
        cmd_in      = '0;
        cmd_in.typ  = bus.cmd_type;
        cmd_in.node = bus.cmd_node;
        cmd_in.addr = bus.cmd_addr;
        cmd_in.data = bus.cmd_data;
    end

    assign ready = (count_q != CNT_W'(FIFO_DEPTH));
    assign push  = bus.cmd_valid && ready && !rst;
    assign head  = fifo_q[rd_ptr_q];

    // The release states dispatch like IDLE so queued commands run without a bubble.
    assign can_dispatch = (state_q == S_IDLE) || (state_q == S_LOAD_REL) ||
                          (state_q == S_TRIG_REL);
    assign pop          = can_dispatch && (count_q != '0);

    assign head_x      = head.node[3:0];
    assign head_y      = head.node[7:4];
    assign node_ok     = (int'(head_x) < MESH_SIZE_X) && (int'(head_y) < MESH_SIZE_Y);
    assign neuron_ok   = int'(head.addr[7:0]) < NUM_NEURONS_PER_BANK;
    assign cmd_ok      = node_ok && (!head.typ || neuron_ok);
    assign node_onehot = NUM_NODES'(1) << (int'(head_y) * MESH_SIZE_X + int'(head_x));

    always_ff @(posedge cpu_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= cmd_in;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        load_sel_d  = '0;
        inj_valid_d = 1'b0;
        err_pulse_d = 1'b0;
        load_addr_d = load_addr_q;
        load_data_d = load_data_q;
        node_sel_d  = node_sel_q;
        neuron_id_d = neuron_id_q;
        current_d   = current_q;

        case (state_q)
            S_LOAD: begin
                state_d = S_LOAD_REL;
            end
            S_INJ: begin
                state_d = S_INJ_GAP;
            end
            S_INJ_GAP: begin
                // Trigger register index is neuron*8+6, truncated to 8 bits.
                state_d     = S_TRIG;
                neuron_id_d = {neuron_id_q[4:0], 3'b110};
                current_d   = 32'h0000_0001;
                inj_valid_d = 1'b1;
            end
            S_TRIG: begin
                state_d = S_TRIG_REL;
            end
            default: begin
                state_d = S_IDLE;
                if (pop) begin
                    if (!cmd_ok) begin
                        err_pulse_d = 1'b1;
                    end else if (!head.typ) begin
                        state_d     = S_LOAD;
                        load_sel_d  = node_onehot;
                        load_addr_d = head.addr;
                        load_data_d = head.data;
                    end else begin
                        state_d     = S_INJ;
                        node_sel_d  = head.node;
                        neuron_id_d = head.addr[7:0];
                        current_d   = head.data;
                        inj_valid_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            load_sel_q  <= '0;
            load_addr_q <= '0;
            load_data_q <= '0;
            node_sel_q  <= '0;
            neuron_id_q <= '0;
            current_q   <= '0;
            inj_valid_q <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_sel_q  <= load_sel_d;
            load_addr_q <= load_addr_d;
            load_data_q <= load_data_d;
            node_sel_q  <= node_sel_d;
            neuron_id_q <= neuron_id_d;
            current_q   <= current_d;
            inj_valid_q <= inj_valid_d;
            err_pulse_q <= err_pulse_d;
        end
    end

`ifdef HOST_STIM_CNT_EN
    logic [15:0] done_count_q;
    logic [7:0]  err_count_q;

    // A command completes in its release state; err_count saturates rather than wraps.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            done_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            if ((state_q == S_LOAD_REL) || (state_q == S_TRIG_REL)) begin
                done_count_q <= done_count_q + 16'd1;
            end
            if (err_pulse_d && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign bus.done_count = done_count_q;
    assign bus.err_count  = err_count_q;
`endif

    assign bus.cmd_ready         = ready;
    assign bus.prog_load_enable  = load_sel_q;
    assign bus.prog_load_write   = load_sel_q;
    assign bus.prog_load_addr    = load_addr_q;
    assign bus.prog_load_data    = load_data_q;
    assign bus.ext_node_select   = node_sel_q;
    assign bus.ext_neuron_id     = neuron_id_q;
    assign bus.ext_input_current = current_q;
    assign bus.ext_input_valid   = inj_valid_q;
    assign bus.busy              = (count_q != '0) || (state_q != S_IDLE);
    assign bus.err_pulse         = err_pulse_q;
    assign bus.dbg_state         = state_q;

    a_strobe_excl: assert property (@(posedge cpu_clk) !(inj_valid_q && (load_sel_q != '0)));
    a_count_bound: assert property (@(posedge cpu_clk) count_q <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_host_stim_sequencer.sv
// Directed bench for host_stim_sequencer: load, inject+trigger, back-to-back,
// queue-full, invalid-command and mid-sequence reset scenarios.
module tb_host_stim_sequencer;
  logic cpu_clk;
  logic rst;

  host_stim_sequencer_if #(.NUM_NODES(4)) bus ();

  host_stim_sequencer #(
    .MESH_SIZE_X(2),
    .MESH_SIZE_Y(2),
    .NUM_NEURONS_PER_BANK(4),
    .FIFO_DEPTH(4)
  ) dut (
    .cpu_clk(cpu_clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int loads_seen = 0;
  logic mon_en = 1'b0;
  logic fifo_mon = 1'b0;
  logic [31:0] exp_q[$];

  // clock / reset
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic push_cmd(input logic typ, input logic [7:0] node,
                          input logic [31:0] addr, input logic [31:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = typ;
    bus.cmd_node  = node;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 50) begin
      tick();
      n++;
    end
    check_eq(tag, {31'b0, bus.busy}, 32'h0);
  endtask

  // scoreboard monitor: strobe exclusivity every cycle, load order in the queue test
  always @(negedge cpu_clk) begin
    if (mon_en) begin
      check_eq("strobe_excl", {31'b0, bus.ext_input_valid && (bus.prog_load_write != '0)}, 32'h0);
      if (fifo_mon && (bus.prog_load_write != '0)) begin
        logic [31:0] exp_addr;
        loads_seen++;
        exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
        check_eq("fifo_order_addr", bus.prog_load_addr, exp_addr);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 1'b0;
    bus.cmd_node  = '0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    check_eq("rst_ready", {31'b0, bus.cmd_ready}, 32'h1);
    check_eq("rst_busy", {31'b0, bus.busy}, 32'h0);
    check_eq("rst_write", {28'b0, bus.prog_load_write}, 32'h0);
    check_eq("rst_valid", {31'b0, bus.ext_input_valid}, 32'h0);
    check_eq("rst_err", {31'b0, bus.err_pulse}, 32'h0);
    check_eq("rst_state", {29'b0, bus.dbg_state}, 32'h0);
`ifdef HOST_STIM_CNT_EN
    check_eq("rst_done_cnt", {16'b0, bus.done_count}, 32'h0);
`endif
    mon_en = 1'b1;

    // load node (1,0) addr 0x0C data 0x6F
    push_cmd(1'b0, 8'h01, 32'h0000_000C, 32'h0000_006F);
    check_eq("ld_busy_queued", {31'b0, bus.busy}, 32'h1);
    check_eq("ld_no_bypass", {28'b0, bus.prog_load_write}, 32'h0);
    tick();
    check_eq("ld_write", {28'b0, bus.prog_load_write}, 32'h2);
    check_eq("ld_enable", {28'b0, bus.prog_load_enable}, 32'h2);
    check_eq("ld_addr", bus.prog_load_addr, 32'h0000_000C);
    check_eq("ld_data", bus.prog_load_data, 32'h0000_006F);
    tick();
    check_eq("ld_rel_write", {28'b0, bus.prog_load_write}, 32'h0);
    check_eq("ld_rel_enable", {28'b0, bus.prog_load_enable}, 32'h0);
    check_eq("ld_rel_addr_hold", bus.prog_load_addr, 32'h0000_000C);
    check_eq("ld_rel_busy", {31'b0, bus.busy}, 32'h1);
    tick();
    check_eq("ld_idle_busy", {31'b0, bus.busy}, 32'h0);

    // inject node (0,0) neuron 1 current 100.0f
    push_cmd(1'b1, 8'h00, 32'h0000_0001, 32'h42C8_0000);
    tick();
    check_eq("inj_valid", {31'b0, bus.ext_input_valid}, 32'h1);
    check_eq("inj_id", {24'b0, bus.ext_neuron_id}, 32'h01);
    check_eq("inj_cur", bus.ext_input_current, 32'h42C8_0000);
    check_eq("inj_node", {24'b0, bus.ext_node_select}, 32'h00);
    tick();
    check_eq("gap_valid", {31'b0, bus.ext_input_valid}, 32'h0);
    check_eq("gap_id_hold", {24'b0, bus.ext_neuron_id}, 32'h01);
    tick();
    check_eq("trig_valid", {31'b0, bus.ext_input_valid}, 32'h1);
    check_eq("trig_id", {24'b0, bus.ext_neuron_id}, 32'h0E);
    check_eq("trig_cur", bus.ext_input_current, 32'h0000_0001);
    tick();
    check_eq("trig_rel_valid", {31'b0, bus.ext_input_valid}, 32'h0);
    check_eq("trig_rel_busy", {31'b0, bus.busy}, 32'h1);
    tick();
    check_eq("inj_idle_busy", {31'b0, bus.busy}, 32'h0);

    // back-to-back: load (1,1) then inject (0,1) neuron 3, second push during the pop
    push_cmd(1'b0, 8'h11, 32'h0000_0020, 32'hDEAD_BEEF);
    push_cmd(1'b1, 8'h10, 32'h0000_0003, 32'h3F80_0000);
    check_eq("b2b_ld_write", {28'b0, bus.prog_load_write}, 32'h8);
    check_eq("b2b_ld_data", bus.prog_load_data, 32'hDEAD_BEEF);
    tick();
    check_eq("b2b_rel_write", {28'b0, bus.prog_load_write}, 32'h0);
    check_eq("b2b_rel_valid", {31'b0, bus.ext_input_valid}, 32'h0);
    tick();
    check_eq("b2b_inj_valid", {31'b0, bus.ext_input_valid}, 32'h1);
    check_eq("b2b_inj_node", {24'b0, bus.ext_node_select}, 32'h10);
    check_eq("b2b_inj_cur", bus.ext_input_current, 32'h3F80_0000);
    repeat (2) tick();
    check_eq("b2b_trig_id", {24'b0, bus.ext_neuron_id}, 32'h1E);
    check_eq("b2b_trig_node", {24'b0, bus.ext_node_select}, 32'h10);
    drain("b2b_drain");

    // queue full while the sequencer is occupied by an inject
    loads_seen = 0;
    fifo_mon = 1'b1;
    push_cmd(1'b1, 8'h00, 32'h0000_0002, 32'h0000_1234);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h100 + i);
      push_cmd(1'b0, 8'h01, 32'h100 + i, 32'hA0 + i);
    end
    check_eq("full_ready", {31'b0, bus.cmd_ready}, 32'h0);
    push_cmd(1'b0, 8'h01, 32'h0000_01FF, 32'h0000_00FF);
    check_eq("after_pop_ready", {31'b0, bus.cmd_ready}, 32'h1);
    drain("fifo_drain");
    fifo_mon = 1'b0;
    check_eq("fifo_loads_seen", loads_seen, 32'd4);
    check_eq("fifo_exp_left", exp_q.size(), 32'd0);

    // invalid commands: x out of range, then neuron out of range
`ifdef HOST_STIM_CNT_EN
    check_eq("done_cnt", {16'b0, bus.done_count}, 32'd9);
`endif
    push_cmd(1'b0, 8'h02, 32'h0000_0004, 32'h0000_0055);
    tick();
    check_eq("err_x_pulse", {31'b0, bus.err_pulse}, 32'h1);
    check_eq("err_x_write", {28'b0, bus.prog_load_write}, 32'h0);
`ifdef HOST_STIM_CNT_EN
    check_eq("err_cnt_1", {24'b0, bus.err_count}, 32'd1);
`endif
    tick();
    check_eq("err_x_pulse_end", {31'b0, bus.err_pulse}, 32'h0);
    check_eq("err_x_busy", {31'b0, bus.busy}, 32'h0);
    push_cmd(1'b1, 8'h00, 32'h0000_0004, 32'h4000_0000);
    tick();
    check_eq("err_n_pulse", {31'b0, bus.err_pulse}, 32'h1);
    check_eq("err_n_valid", {31'b0, bus.ext_input_valid}, 32'h0);
    tick();
    check_eq("err_n_pulse_end", {31'b0, bus.err_pulse}, 32'h0);
    check_eq("err_n_valid_after", {31'b0, bus.ext_input_valid}, 32'h0);

    // reset during INJ_GAP, with a command offered while reset is high
    push_cmd(1'b1, 8'h01, 32'h0000_0002, 32'h1111_1111);
    tick();
    check_eq("rstgap_inj_valid", {31'b0, bus.ext_input_valid}, 32'h1);
    tick();
    check_eq("rstgap_gap_valid", {31'b0, bus.ext_input_valid}, 32'h0);
    rst = 1'b1;
    push_cmd(1'b0, 8'h00, 32'h0000_0077, 32'h0000_0088);
    rst = 1'b0;
    check_eq("rstgap_valid", {31'b0, bus.ext_input_valid}, 32'h0);
    check_eq("rstgap_busy", {31'b0, bus.busy}, 32'h0);
    check_eq("rstgap_node_clr", {24'b0, bus.ext_node_select}, 32'h0);
    check_eq("rstgap_cur_clr", bus.ext_input_current, 32'h0);
    tick();
    check_eq("rstgap_no_trig", {31'b0, bus.ext_input_valid}, 32'h0);
    check_eq("rstgap_queue_empty", {31'b0, bus.busy}, 32'h0);
    check_eq("rstgap_ready", {31'b0, bus.cmd_ready}, 32'h1);
    tick();
    check_eq("rstgap_no_load", {28'b0, bus.prog_load_write}, 32'h0);
`ifdef HOST_STIM_CNT_EN
    check_eq("rstgap_done_cnt", {16'b0, bus.done_count}, 32'd0);
    check_eq("rstgap_err_cnt", {24'b0, bus.err_count}, 32'd0);
`endif

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/host_stim_sequencer.md
HOST_STIM_SEQUENCER -- requirements
Module: host_stim_sequencer

Interface
REQ-001 SHALL have parameter MESH_SIZE_X, default 2, mesh columns.
REQ-002 SHALL have parameter MESH_SIZE_Y, default 2, mesh rows; NUM_NODES = MESH_SIZE_X*MESH_SIZE_Y.
REQ-003 SHALL have parameter NUM_NEURONS_PER_BANK, default 4, neurons per node.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of two), command queue entries.
REQ-005 SHALL have port cpu_clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port cmd_valid  input  1  host command valid.
REQ-008 SHALL have port cmd_ready  output  1  queue can accept; = !full.
REQ-009 SHALL have port cmd_type  input  1  0 = program-load word, 1 = current injection.
REQ-010 SHALL have port cmd_node  input  8  {y[7:4], x[3:0]} target node.
REQ-011 SHALL have port cmd_addr  input  32  load: instruction address; inject: neuron id in [7:0].
REQ-012 SHALL have port cmd_data  input  32  load: instruction word; inject: FP32 current.
REQ-013 SHALL have port prog_load_enable  output  NUM_NODES  one-hot node select for load.
REQ-014 SHALL have port prog_load_write  output  NUM_NODES  one-hot write strobe for load.
REQ-015 SHALL have port prog_load_addr  output  32  load address.
REQ-016 SHALL have port prog_load_data  output  32  load data.
REQ-017 SHALL have port ext_node_select  output  8  {y, x} of injection target.
REQ-018 SHALL have port ext_neuron_id  output  8  neuron id or trigger register index.
REQ-019 SHALL have port ext_input_current  output  32  injected value.
REQ-020 SHALL have port ext_input_valid  output  1  injection strobe.
REQ-021 SHALL have port busy  output  1  high when queue non-empty or FSM not IDLE.
REQ-022 SHALL have port err_pulse  output  1  one-cycle pulse when a command is dropped.

Function
REQ-023 SHALL push {type,node,addr,data} into a FIFO_DEPTH FIFO on cmd_valid&&cmd_ready; no bypass, no push when full.
REQ-024 SHALL run FSM states IDLE, LOAD, LOAD_REL, INJ, INJ_GAP, TRIG, TRIG_REL; all outputs registered.
REQ-025 SHALL in IDLE with queue non-empty pop the head and go to LOAD (type 0) or INJ (type 1) on the same edge; command pushed at edge k drives outputs in cycle after edge k+1 when FSM idle and queue empty.
REQ-026 SHALL validate popped command: x<MESH_SIZE_X, y<MESH_SIZE_Y, and for inject neuron<NUM_NEURONS_PER_BANK; invalid -> stay IDLE, pulse err_pulse 1 cycle, drive no strobes.
REQ-027 SHALL in LOAD drive prog_load_enable = prog_load_write = 1<<(y*MESH_SIZE_X+x), addr, data for exactly 1 cycle; LOAD_REL drives both to 0 for 1 cycle, then IDLE.
REQ-028 SHALL in INJ drive ext_node_select=node, ext_neuron_id=neuron, ext_input_current=data, ext_input_valid=1 for 1 cycle; INJ_GAP valid=0 1 cycle.
REQ-029 SHALL in TRIG drive ext_neuron_id = neuron*8+6 (8-bit, truncating), ext_input_current=32'h00000001, ext_input_valid=1 for 1 cycle; TRIG_REL valid=0 1 cycle, then IDLE.
REQ-030 SHALL keep addr/data/node/neuron/current outputs holding last driven values when strobes low.
REQ-031 SHALL give load command 2-cycle occupancy, inject 4-cycle occupancy; back-to-back queued commands start in the cycle after *_REL with no idle bubble.
REQ-032 SHALL accept a push while the FSM pops on the same edge when not full; count stays consistent (push and pop simultaneous -> count unchanged).
REQ-033 SHALL never assert ext_input_valid and any prog_load_write in the same cycle.

Reset
REQ-034 SHALL on rst clear FIFO pointers/count, FSM to IDLE, all outputs 0, cmd_ready=1 from the next cycle, busy=0, including mid-sequence (aborted strobe drops that edge).
REQ-035 SHALL ignore cmd_valid while rst is high.

Configuration
REQ-036 SHALL with HOST_STIM_CNT_EN defined add outputs done_count[15:0] (increments per completed command, wraps) and err_count[7:0] (increments per err_pulse, saturates at 255), both cleared by rst.
REQ-037 SHALL without HOST_STIM_CNT_EN omit both ports and counters; all other behaviour identical.

Verification
REQ-038 SHALL test load node (1,0) addr 0x0C data 0x0000006F -> prog_load_write=4'b0010 one cycle, addr/data match, then 0.
REQ-039 SHALL test inject node (0,0) neuron 1 current 0x42C80000 -> valid pulse id=1 cur=0x42C80000, gap cycle, valid pulse id=0x0E cur=1.
REQ-040 SHALL test 5 pushes with FIFO_DEPTH=4 while FSM stalled -> cmd_ready low after 4th, 5th not accepted, all 4 execute in order.
REQ-041 SHALL test node (2,0) or neuron 4 -> err_pulse 1 cycle, no strobes, err_count=1 with HOST_STIM_CNT_EN.
REQ-042 SHALL test rst asserted during INJ_GAP -> ext_input_valid stays 0, no TRIG, busy=0, queue empty.
